// File: rtl/booth_mult_seq_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_RUN,
        S_DONE
    } state_t;

    // Booth bit-pair codes for {Q[0], Q-1}
    localparam logic [1:0] BP_ADD = 2'b01;
    localparam logic [1:0] BP_SUB = 2'b10;

    // Step counter must hold WIDTH+1
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq.
interface booth_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       data_in;
    logic                   in_valid;
    logic                   in_ready;
    logic                   signed_mode;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, data_in, in_valid, signed_mode, out_ready,
        input  in_ready, busy, out_valid, result
    );

    modport slave (
        input  start, data_in, in_valid, signed_mode, out_ready,
        output in_ready, busy, out_valid, result
    );
endinterface

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift of {A,Q,Q-1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N-1:0] m,
    output logic [N-1:0] a_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q_m1_nxt
);
    logic [N-1:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            BP_ADD:  sum = a + m;
            BP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        {a_nxt, q_nxt, q_m1_nxt} = {sum[N-1], sum, q};
    end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier; operands arrive serially on one bus, signed or unsigned.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    booth_mult_seq_if.slave     bus
);
    // One extra bit lets unsigned operands run through the signed Booth datapath exactly
    localparam int N  = WIDTH + 1;
    localparam int CW = cnt_w(WIDTH);

    state_t             state, state_n;
    logic               smode;
    logic [N-1:0]       m_reg, a_reg, q_reg;
    logic               q_m1;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] result_reg;

    logic [N-1:0]       a_nxt, q_nxt;
    logic               q_m1_nxt;

    function automatic logic [N-1:0] ext(input logic [WIDTH-1:0] x, input logic sgn);
        return {sgn & x[WIDTH-1], x};
    endfunction

    booth_step #(.N(N)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_m1     (q_m1),
        .m        (m_reg),
        .a_nxt    (a_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_n = S_LOAD_A;
            end
            S_LOAD_A: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_n = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_n = S_RUN;
            end
            S_RUN: begin
                if (cnt == CW'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smode      <= 1'b0;
            m_reg      <= '0;
            a_reg      <= '0;
            q_reg      <= '0;
            q_m1       <= 1'b0;
            cnt        <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) smode <= bus.signed_mode;
                S_LOAD_A: if (bus.in_valid) m_reg <= ext(bus.data_in, smode);
                S_LOAD_B: if (bus.in_valid) begin
                    q_reg <= ext(bus.data_in, smode);
                    a_reg <= '0;
                    q_m1  <= 1'b0;
                    cnt   <= CW'(N);
                end
                S_RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    q_m1  <= q_m1_nxt;
                    cnt   <= cnt - CW'(1);
                    // Last step: low 2*WIDTH bits of {A,Q} are the exact product
                    if (cnt == CW'(1)) result_reg <= {a_nxt[WIDTH-2:0], q_nxt};
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomized and directed checks of booth_mult_seq at WIDTH=16 and WIDTH=4 against plain multiplication.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(16)) b16 ();
    booth_mult_seq_if #(.WIDTH(4))  b4  ();

    booth_mult_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
    booth_mult_seq #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit s, input int w);
        longint va, vb, p, mask;
        mask = (longint'(1) << w) - 1;
        va = longint'(a) & mask;
        vb = longint'(b) & mask;
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        p = va * vb;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit s,
                         input int stall, input int bp, input bit stray);
        int lat;
        logic [63:0] exp;
        logic [31:0] held;
        exp = ref_mul(32'(a), 32'(b), s, 16);
        b16.start = 1; b16.signed_mode = s; b16.data_in = a; b16.in_valid = 1; b16.out_ready = 0;
        @(posedge clk); #1; lat = 0;
        b16.start = 0; b16.signed_mode = ~s;
        chk("in_ready_load", 64'(b16.in_ready), 1);
        @(posedge clk); #1; lat++;
        b16.data_in = b;
        if (stall > 0) b16.in_valid = 0;
        repeat (stall) begin @(posedge clk); #1; lat++; end
        b16.in_valid = 1;
        @(posedge clk); #1; lat++;
        b16.in_valid = 0; b16.data_in = 16'($urandom);
        while (!b16.out_valid && lat < 200) begin
            if (stray) b16.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
        end
        b16.start = 0;
        chk("lat16", 64'(lat), 64'(19 + stall));
        chk("res16", 64'(b16.result), exp);
        if (bp > 0) begin
            held = b16.result;
            repeat (bp) begin @(posedge clk); #1; end
            chk("bp_valid", 64'(b16.out_valid), 1);
            chk("bp_hold", 64'(b16.result), 64'(held));
        end
        b16.out_ready = 1; b16.start = 1;
        @(posedge clk); #1;
        b16.out_ready = 0; b16.start = 0;
        chk("hs_idle", 64'(b16.busy), 0);
        @(posedge clk); #1;
        chk("hs_start_ignored", 64'(b16.busy), 0);
        chk("res_hold", 64'(b16.result), exp);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit s);
        int lat;
        b4.start = 1; b4.signed_mode = s; b4.data_in = a; b4.in_valid = 1; b4.out_ready = 1;
        @(posedge clk); #1; lat = 0;
        b4.start = 0;
        @(posedge clk); #1; lat++;
        b4.data_in = b;
        @(posedge clk); #1; lat++;
        b4.in_valid = 0;
        while (!b4.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk($sformatf("res4 %0h*%0h s%0d", a, b, s), 64'(b4.result), ref_mul(32'(a), 32'(b), s, 4));
        if (lat != 7) chk("lat4", 64'(lat), 7);
        @(posedge clk); #1;
    endtask

    initial begin
        b16.start = 0; b16.data_in = 0; b16.in_valid = 0; b16.signed_mode = 0; b16.out_ready = 0;
        b4.start = 0;  b4.data_in = 0;  b4.in_valid = 0;  b4.signed_mode = 0;  b4.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(b16.busy), 0);
        chk("rst_in_ready", 64'(b16.in_ready), 0);
        chk("rst_out_valid", 64'(b16.out_valid), 0);
        chk("rst_result", 64'(b16.result), 0);
        chk("rst_result4", 64'(b4.result), 0);
        rst = 0;
        @(posedge clk); #1;

        run16(16'd10, 16'd13, 0, 0, 0, 0);
        run16(16'hFFFD, 16'd7, 1, 0, 0, 0);
        run16(16'h8000, 16'h8000, 1, 0, 0, 0);
        run16(16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        run16(16'hFFFF, 16'hFFFF, 1, 0, 0, 0);
        run16(16'h8000, 16'hFFFF, 0, 0, 0, 0);
        run16(16'd1234, 16'd321, 0, 0, 5, 0);
        run16(16'hABCD, 16'h1357, 1, 3, 0, 0);
        run16(16'h7FFF, 16'h8001, 1, 0, 0, 1);

        // abort mid-RUN with reset
        b16.start = 1; b16.signed_mode = 0; b16.data_in = 16'd1234; b16.in_valid = 1;
        @(posedge clk); #1; b16.start = 0;
        @(posedge clk); #1; b16.data_in = 16'd5678;
        @(posedge clk); #1; b16.in_valid = 0;
        repeat (5) @(posedge clk);
        #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        chk("abort_busy", 64'(b16.busy), 0);
        chk("abort_in_ready", 64'(b16.in_ready), 0);
        chk("abort_out_valid", 64'(b16.out_valid), 0);
        chk("abort_result", 64'(b16.result), 0);
        run16(16'd6, 16'd7, 0, 0, 0, 0);
        chk("after_abort_42", 64'(b16.result), 42);

        for (int i = 0; i < 20; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom));

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(4'(a), 4'(b), 1'(s));
        for (int i = 0; i < 40; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
